uart2_txrx: RTL and testbench

- Full-duplex 8N1/8N2 UART channel clocked by the system clock `clk_sis`.
- The transmitter serializes a locally requested byte onto `tx2`.
- The receiver deserializes frames arriving on `rx2`. Each byte it receives error-free is echoed back out on `tx2`.
- Bit timing comes from an oversampling tick enable `clk_uart` supplied by an external baud generator. The block sits between the system bus side and the UART line pins.

---
 rtl/uart2_txrx_if.sv | 27 ++
 rtl/uart2_txrx.sv | 206 ++++++++++++++++++++
 tb/tb_uart2_txrx.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart2_txrx_if.sv
// Line-side and request signals of the uart2_txrx channel, plus read-only
// views of both FSM states so checkers can follow the block's progress.
interface uart2_txrx_if #(
    parameter int DATA_BITS = 8
);
    logic                 start_bit;
    logic [DATA_BITS-1:0] data_in;
    logic                 stop_bit;
    logic                 tx2;
    logic                 rx2;
    logic [2:0]           tx_state;
    logic [1:0]           rx_state;

    // start_bit is a request (valid) sampled every clk_sis cycle. Ready is implicit:
    // a request is taken only while tx_state is idle, and a request made at any
    // other time is dropped, not queued. data_in/stop_bit need only be stable in
    // the cycle that start_bit is taken.
    modport master (
        output start_bit, data_in, stop_bit, rx2,
        input  tx2, tx_state, rx_state
    );

    modport slave (
        input  start_bit, data_in, stop_bit, rx2,
        output tx2, tx_state, rx_state
    );
endinterface

// File: rtl/uart2_txrx.sv
// Full-duplex UART channel: sends locally requested bytes and echoes every
// correctly framed received byte back out on tx2.
module uart2_txrx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic        clk_sis,
    input  logic        rst,
    input  logic        clk_uart,
    uart2_txrx_if.slave bus
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_START = 3'd1,
        TX_DATA  = 3'd2,
        TX_STOP1 = 3'd3,
        TX_STOP2 = 3'd4
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    tx_state_e            tx_state_q, tx_state_d;
    logic [TW-1:0]        tx_tick_q, tx_tick_d;
    logic [BW-1:0]        tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_two_stop_q, tx_two_stop_d;
    logic                 tx_line_q, tx_line_d;
    logic                 echo_take;

    rx_state_e            rx_state_q, rx_state_d;
    logic [TW-1:0]        rx_tick_q, rx_tick_d;
    logic [BW-1:0]        rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_last_q, rx_last_d;
    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic                 rx_done;

    logic                 echo_valid_q, echo_valid_d;
    logic [DATA_BITS-1:0] echo_data_q, echo_data_d;

    // Transmitter: a local request outranks a pending echo in the same cycle.
    always_comb begin
        tx_state_d    = tx_state_q;
        tx_tick_d     = tx_tick_q;
        tx_bit_d      = tx_bit_q;
        tx_shift_d    = tx_shift_q;
        tx_two_stop_d = tx_two_stop_q;
        tx_line_d     = tx_line_q;
        echo_take     = 1'b0;
        if (tx_state_q == TX_IDLE) begin
            tx_line_d = 1'b1;
            tx_tick_d = '0;
            tx_bit_d  = '0;
            if (bus.start_bit) begin
                tx_shift_d    = bus.data_in;
                tx_two_stop_d = bus.stop_bit;
                tx_state_d    = TX_START;
                tx_line_d     = 1'b0;
            end else if (echo_valid_q) begin
                tx_shift_d    = echo_data_q;
                tx_two_stop_d = 1'b0;
                tx_state_d    = TX_START;
                tx_line_d     = 1'b0;
                echo_take     = 1'b1;
            end
        end else if (clk_uart) begin
            if (tx_tick_q != TICK_LAST) begin
                tx_tick_d = tx_tick_q + TW'(1);
            end else begin
                tx_tick_d = '0;
                case (tx_state_q)
                    TX_START: begin
                        tx_state_d = TX_DATA;
                        tx_line_d  = tx_shift_q[0];
                    end
                    TX_DATA: begin
                        if (tx_bit_q == BIT_LAST) begin
                            tx_state_d = TX_STOP1;
                            tx_line_d  = 1'b1;
                        end else begin
                            tx_bit_d   = tx_bit_q + BW'(1);
                            tx_shift_d = tx_shift_q >> 1;
                            tx_line_d  = tx_shift_d[0];
                        end
                    end
                    TX_STOP1: tx_state_d = tx_two_stop_q ? TX_STOP2 : TX_IDLE;
                    default:  tx_state_d = TX_IDLE;
                endcase
            end
        end
    end

    // Receiver: start edge and all samples are taken on tick cycles only.
    always_comb begin
        sync1_d    = bus.rx2;
        sync2_d    = sync1_q;
        rx_state_d = rx_state_q;
        rx_tick_d  = rx_tick_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_last_d  = rx_last_q;
        rx_done    = 1'b0;
        if (clk_uart) begin
            rx_last_d = sync2_q;
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_last_q && !sync2_q) begin
                        rx_state_d = RX_START;
                        rx_tick_d  = '0;
                    end
                end
                RX_START: begin
                    if (rx_tick_q == TICK_HALF) begin
                        rx_tick_d  = '0;
                        rx_bit_d   = '0;
                        rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_tick_d = rx_tick_q + TW'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_tick_q == TICK_LAST) begin
                        rx_tick_d  = '0;
                        rx_shift_d = {sync2_q, rx_shift_q[DATA_BITS-1:1]};
                        if (rx_bit_q == BIT_LAST) rx_state_d = RX_STOP;
                        else                      rx_bit_d   = rx_bit_q + BW'(1);
                    end else begin
                        rx_tick_d = rx_tick_q + TW'(1);
                    end
                end
                default: begin
                    if (rx_tick_q == TICK_LAST) begin
                        rx_tick_d  = '0;
                        rx_done    = sync2_q;
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_tick_d = rx_tick_q + TW'(1);
                    end
                end
            endcase
        end
    end

    // A new reception overwrites the buffer even if TX takes the old byte this cycle.
    always_comb begin
        echo_valid_d = echo_valid_q;
        echo_data_d  = echo_data_q;
        if (echo_take) echo_valid_d = 1'b0;
        if (rx_done) begin
            echo_valid_d = 1'b1;
            echo_data_d  = rx_shift_q;
        end
    end

    always_ff @(posedge clk_sis or negedge rst) begin
        if (!rst) begin
            tx_state_q    <= TX_IDLE;
            tx_tick_q     <= '0;
            tx_bit_q      <= '0;
            tx_shift_q    <= '0;
            tx_two_stop_q <= 1'b0;
            tx_line_q     <= 1'b1;
            rx_state_q    <= RX_IDLE;
            rx_tick_q     <= '0;
            rx_bit_q      <= '0;
            rx_shift_q    <= '0;
            rx_last_q     <= 1'b1;
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            echo_valid_q  <= 1'b0;
            echo_data_q   <= '0;
        end else begin
            tx_state_q    <= tx_state_d;
            tx_tick_q     <= tx_tick_d;
            tx_bit_q      <= tx_bit_d;
            tx_shift_q    <= tx_shift_d;
            tx_two_stop_q <= tx_two_stop_d;
            tx_line_q     <= tx_line_d;
            rx_state_q    <= rx_state_d;
            rx_tick_q     <= rx_tick_d;
            rx_bit_q      <= rx_bit_d;
            rx_shift_q    <= rx_shift_d;
            rx_last_q     <= rx_last_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            echo_valid_q  <= echo_valid_d;
            echo_data_q   <= echo_data_d;
        end
    end

    assign bus.tx2      = tx_line_q;
    assign bus.tx_state = tx_state_q;
    assign bus.rx_state = rx_state_q;
endmodule

// File: tb/tb_uart2_txrx.sv
// Bench for uart2_txrx: a line decoder on tx2 turns frames back into bytes and
// tick-stamped start times, which are compared with bytes the bench predicts.
module tb_uart2_txrx;
    localparam int OS        = 16;
    localparam int DATA_BITS = 8;
    localparam int BIT_CYC   = OS * 4;

    localparam logic [1:0] K_LOCAL  = 2'd0;
    localparam logic [1:0] K_RX     = 2'd1;
    localparam logic [1:0] K_GLITCH = 2'd2;

    typedef struct {
        logic [1:0] kind;
        logic [7:0] data;
        logic       stop;
        logic       exp_out;
        logic [7:0] exp_byte;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       stop1;
        int         t0;
    } frame_t;

    logic clk_sis = 1'b0;
    logic rst;
    logic clk_uart = 1'b0;
    uart2_txrx_if #(.DATA_BITS(DATA_BITS)) u_if ();

    uart2_txrx #(.OVERSAMPLE(OS), .DATA_BITS(DATA_BITS)) dut (
        .clk_sis (clk_sis),
        .rst     (rst),
        .clk_uart(clk_uart),
        .bus     (u_if)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    int         tick_cnt = 0;
    int         div      = 0;
    logic       mon_en   = 1'b0;
    frame_t     mon_q[$];
    logic [7:0] exp_q[$];
    vec_t       vecs[8];

    // ---------------- clock, tick and reset block ----------------
    always #5 clk_sis = ~clk_sis;

    initial begin
        forever begin
            @(negedge clk_sis);
            div      = (div + 1) % 4;
            clk_uart = (div == 0);
        end
    end

    initial begin
        forever begin
            @(posedge clk_sis);
            if (clk_uart) tick_cnt++;
        end
    end

    initial begin
        #950_000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks so far", n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- tx2 line decoder ----------------
    frame_t mon_f;
    int     mon_t0;
    logic   mon_abort;

    initial begin
        forever begin
            @(negedge clk_sis);
            if (rst && mon_en && u_if.tx2 == 1'b0) begin
                mon_t0    = tick_cnt;
                mon_abort = 1'b0;
                for (int k = 1; k <= DATA_BITS + 1; k++) begin
                    while (!mon_abort && tick_cnt != mon_t0 + k * OS + OS / 2) begin
                        @(negedge clk_sis);
                        if (!rst) mon_abort = 1'b1;
                    end
                    if (k <= DATA_BITS) mon_f.data[k-1] = u_if.tx2;
                    else                mon_f.stop1     = u_if.tx2;
                end
                if (!mon_abort) begin
                    mon_f.t0 = mon_t0;
                    mon_q.push_back(mon_f);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_local(input logic [7:0] d, input logic s);
        @(negedge clk_sis);
        u_if.start_bit = 1'b1;
        u_if.data_in   = d;
        u_if.stop_bit  = s;
        @(negedge clk_sis);
        u_if.start_bit = 1'b0;
    endtask

    task automatic rx_frame(input logic [7:0] d, input logic stop_val);
        u_if.rx2 = 1'b0;
        repeat (BIT_CYC) @(negedge clk_sis);
        for (int i = 0; i < DATA_BITS; i++) begin
            u_if.rx2 = d[i];
            repeat (BIT_CYC) @(negedge clk_sis);
        end
        u_if.rx2 = stop_val;
        repeat (BIT_CYC) @(negedge clk_sis);
        u_if.rx2 = 1'b1;
    endtask

    task automatic glitch(input int cycles);
        u_if.rx2 = 1'b0;
        repeat (cycles) @(negedge clk_sis);
        u_if.rx2 = 1'b1;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_frame(input string name, input logic [7:0] exp_byte,
                                input int budget, output int t0);
        frame_t f;
        int     waited;
        waited = 0;
        t0     = -1;
        while (mon_q.size() == 0 && waited < budget) begin
            @(negedge clk_sis);
            waited++;
        end
        if (mon_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: no frame on tx2 within %0d cycles, expected byte %02h",
                     name, budget, exp_byte);
        end else begin
            f = mon_q.pop_front();
            check({name, "_data"}, 32'(f.data), 32'(exp_byte));
            check({name, "_stop"}, 32'(f.stop1), 32'd1);
            t0 = f.t0;
        end
    endtask

    task automatic quiet(input string name, input int cycles);
        repeat (cycles) @(negedge clk_sis);
        check(name, 32'(mon_q.size()), 32'd0);
        mon_q.delete();
    endtask

    task automatic count_low(input int cycles, output int lows);
        lows = 0;
        repeat (cycles) begin
            @(negedge clk_sis);
            if (u_if.tx2 !== 1'b1) lows++;
        end
    endtask

    // ---------------- test sequence ----------------
    int         t_a, t_b, t_c, lows, kind, dly;
    logic [7:0] d, d2, exp_b;
    logic       s;

    initial begin
        u_if.start_bit = 1'b0;
        u_if.data_in   = '0;
        u_if.stop_bit  = 1'b0;
        u_if.rx2       = 1'b1;
        rst            = 1'b1;

        vecs[0] = '{K_LOCAL,  8'hA5, 1'b0, 1'b1, 8'hA5};
        vecs[1] = '{K_LOCAL,  8'h3C, 1'b1, 1'b1, 8'h3C};
        vecs[2] = '{K_RX,     8'h5A, 1'b1, 1'b1, 8'h5A};
        vecs[3] = '{K_RX,     8'h77, 1'b0, 1'b0, 8'h00};
        vecs[4] = '{K_GLITCH, 8'h00, 1'b0, 1'b0, 8'h00};
        vecs[5] = '{K_LOCAL,  8'h00, 1'b1, 1'b1, 8'h00};
        vecs[6] = '{K_RX,     8'hFF, 1'b1, 1'b1, 8'hFF};
        vecs[7] = '{K_LOCAL,  8'h80, 1'b0, 1'b1, 8'h80};

        // Power-on reset.
        repeat (2) @(negedge clk_sis);
        rst = 1'b0;
        #1 check("reset_tx2", 32'(u_if.tx2), 32'd1);
        repeat (3) @(negedge clk_sis);
        rst = 1'b1;
        count_low(50, lows);
        check("idle_after_por", 32'(lows), 32'd0);

        // Reset mid-frame forces tx2 high without waiting for a clock edge.
        send_local(8'h00, 1'b0);
        repeat (200) @(negedge clk_sis);
        check("pre_reset_low", 32'(u_if.tx2), 32'd0);
        #2 rst = 1'b0;
        #1 check("async_reset_tx2", 32'(u_if.tx2), 32'd1);
        repeat (3) @(negedge clk_sis);
        rst = 1'b1;
        count_low(1000, lows);
        check("idle_after_midframe_reset", 32'(lows), 32'd0);

        // A buffered echo is discarded by reset.
        fork
            send_local(8'h00, 1'b1);
            rx_frame(8'h5A, 1'b1);
        join
        repeat (10) @(negedge clk_sis);
        rst = 1'b0;
        repeat (3) @(negedge clk_sis);
        rst = 1'b1;
        count_low(1500, lows);
        check("echo_cleared_by_reset", 32'(lows), 32'd0);

        mon_q.delete();
        mon_en = 1'b1;

        // Table-driven single-frame cases.
        for (int i = 0; i < 8; i++) begin
            case (vecs[i].kind)
                K_LOCAL: begin
                    send_local(vecs[i].data, vecs[i].stop);
                    repeat (300) @(negedge clk_sis);
                    send_local(8'hEE, 1'b0);
                end
                K_RX:    rx_frame(vecs[i].data, vecs[i].stop);
                default: glitch(20);
            endcase
            if (vecs[i].exp_out)
                expect_frame($sformatf("vec%0d", i), vecs[i].exp_byte, 2500, t_a);
            quiet($sformatf("vec%0d_quiet", i), vecs[i].exp_out ? 800 : 1500);
        end

        // Held request: back-to-back frames, length set by the stop select.
        @(negedge clk_sis);
        u_if.data_in   = 8'h3C;
        u_if.stop_bit  = 1'b1;
        u_if.start_bit = 1'b1;
        repeat (750) @(negedge clk_sis);
        u_if.start_bit = 1'b0;
        expect_frame("b2b_two_a", 8'h3C, 2000, t_a);
        expect_frame("b2b_two_b", 8'h3C, 2000, t_b);
        check("b2b_two_len", 32'(t_b - t_a), 32'(11 * OS));
        quiet("b2b_two_quiet", 800);

        @(negedge clk_sis);
        u_if.data_in   = 8'hC3;
        u_if.stop_bit  = 1'b0;
        u_if.start_bit = 1'b1;
        repeat (680) @(negedge clk_sis);
        u_if.start_bit = 1'b0;
        expect_frame("b2b_one_a", 8'hC3, 2000, t_a);
        expect_frame("b2b_one_b", 8'hC3, 2000, t_b);
        check("b2b_one_len", 32'(t_b - t_a), 32'(10 * OS));
        quiet("b2b_one_quiet", 800);

        // Echo received during a local frame follows it after one idle cycle.
        fork
            send_local(8'hF0, 1'b0);
            begin
                repeat (2) @(negedge clk_sis);
                rx_frame(8'h33, 1'b1);
            end
        join
        expect_frame("arb_local", 8'hF0, 2000, t_a);
        expect_frame("arb_echo", 8'h33, 2000, t_b);
        check("arb_gap", 32'(t_b - t_a), 32'(10 * OS));
        quiet("arb_quiet", 800);

        // Local request and pending echo in the same cycle: local goes first.
        @(negedge clk_sis);
        u_if.data_in   = 8'h11;
        u_if.stop_bit  = 1'b0;
        u_if.start_bit = 1'b1;
        fork
            begin
                @(negedge clk_sis);
                u_if.data_in = 8'h44;
                repeat (678) @(negedge clk_sis);
                u_if.start_bit = 1'b0;
            end
            begin
                repeat (2) @(negedge clk_sis);
                rx_frame(8'h22, 1'b1);
            end
        join
        expect_frame("tie_first", 8'h11, 2000, t_a);
        expect_frame("tie_local", 8'h44, 2000, t_b);
        expect_frame("tie_echo", 8'h22, 2000, t_c);
        check("tie_gap1", 32'(t_b - t_a), 32'(10 * OS));
        check("tie_gap2", 32'(t_c - t_b), 32'(10 * OS));
        quiet("tie_quiet", 800);

        // Randomized traffic against the byte-level reference model.
        for (int it = 0; it < 10; it++) begin
            kind = $urandom_range(0, 3);
            d    = 8'($urandom_range(0, 255));
            d2   = 8'($urandom_range(0, 255));
            s    = 1'($urandom_range(0, 1));
            dly  = $urandom_range(0, 40);
            case (kind)
                0: begin
                    exp_q.push_back(d);
                    send_local(d, s);
                end
                1: begin
                    exp_q.push_back(d);
                    rx_frame(d, 1'b1);
                end
                2: rx_frame(d, 1'b0);
                default: begin
                    exp_q.push_back(d);
                    exp_q.push_back(d2);
                    fork
                        send_local(d, s);
                        begin
                            repeat (dly) @(negedge clk_sis);
                            rx_frame(d2, 1'b1);
                        end
                    join
                end
            endcase
            while (exp_q.size() > 0) begin
                exp_b = exp_q.pop_front();
                expect_frame($sformatf("rand%0d", it), exp_b, 2500, t_a);
            end
            quiet($sformatf("rand%0d_quiet", it), 800);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
